// File: rtl/game_pkg.sv
// Shared game constants and encodings used by the paddle sequencer and its bench.
package game_pkg;

    localparam int unsigned CW       = 13;
    localparam int unsigned SCREEN_H = 1920;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_DECIDE = 2'd2,
        S_PULSE  = 2'd3
    } state_t;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Control bundle between the game logic and one paddle sequencer.
interface paddle_ctrl_if;
    import game_pkg::*;

    logic          frame_tick;
    logic          round_restart;
    logic          freeze;
    logic          cpu_mode;
    logic          btn_up_raw;
    logic          btn_down_raw;
    logic [CW-1:0] ball_y;
    logic [CW-1:0] paddle_y;
    logic          paddle_rst;
    logic          move_up;
    logic          move_down;
    logic          busy;

    modport master (
        output frame_tick, round_restart, freeze, cpu_mode, btn_up_raw, btn_down_raw,
        output ball_y, paddle_y,
        input  paddle_rst, move_up, move_down, busy
    );

    modport slave (
        input  frame_tick, round_restart, freeze, cpu_mode, btn_up_raw, btn_down_raw,
        input  ball_y, paddle_y,
        output paddle_rst, move_up, move_down, busy
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-level debounce counter.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned   CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized input matches the level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Per-paddle frame sequencer: one move decision per frame from buttons or ball-tracking AI.
module paddle_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DEAD_ZONE       = 16,
    parameter int unsigned AI_DIV          = 2
) (
    input logic         clk,
    input logic         rst,
    paddle_ctrl_if.slave ctrl_io
);

    localparam int unsigned     DivW     = (AI_DIV > 1) ? $clog2(AI_DIV) : 1;
    localparam logic [DivW-1:0] DivLast  = DivW'(AI_DIV - 1);
    localparam logic [CW:0]     DeadZone = (CW + 1)'(DEAD_ZONE);

    state_t          state_q;
    dir_t            dir_q, dir_d;
    logic [DivW-1:0] div_q;
    logic            deb_up, deb_down;
    logic [CW:0]     ball_ext, pad_ext;
    logic            ai_up, ai_down;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk  (clk),
        .rst  (rst),
        .raw  (ctrl_io.btn_up_raw),
        .level(deb_up)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk  (clk),
        .rst  (rst),
        .raw  (ctrl_io.btn_down_raw),
        .level(deb_down)
    );

    // One extra bit so the dead-zone offset can never wrap.
    assign ball_ext = {1'b0, ctrl_io.ball_y};
    assign pad_ext  = {1'b0, ctrl_io.paddle_y};
    assign ai_up    = (ball_ext + DeadZone) < pad_ext;
    assign ai_down  = ball_ext > (pad_ext + DeadZone);

    always_comb begin
        dir_d = DIR_NONE;
        if (ctrl_io.cpu_mode) begin
            if (div_q == '0) begin
                if (ai_up) begin
                    dir_d = DIR_UP;
                end else if (ai_down) begin
                    dir_d = DIR_DOWN;
                end
            end
        end else if (deb_up && !deb_down) begin
            dir_d = DIR_UP;
        end else if (deb_down && !deb_up) begin
            dir_d = DIR_DOWN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            dir_q   <= DIR_NONE;
            div_q   <= '0;
        end else if (ctrl_io.round_restart) begin
            state_q <= S_INIT;
            dir_q   <= DIR_NONE;
        end else begin
            unique case (state_q)
                S_INIT: begin
                    div_q   <= '0;
                    state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (ctrl_io.frame_tick && !ctrl_io.freeze) begin
                        state_q <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (ctrl_io.cpu_mode) begin
                        div_q <= (div_q == DivLast) ? '0 : div_q + 1'b1;
                    end
                    dir_q   <= dir_d;
                    state_q <= S_PULSE;
                end
                S_PULSE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state; rst gating keeps paddle_rst low in reset.
    assign ctrl_io.paddle_rst = (state_q == S_INIT) && !rst;
    assign ctrl_io.move_up    = (state_q == S_PULSE) && (dir_q == DIR_UP);
    assign ctrl_io.move_down  = (state_q == S_PULSE) && (dir_q == DIR_DOWN);
    assign ctrl_io.busy       = (state_q != S_IDLE);

endmodule
